// File: rtl/atm_pkg.sv
// Shared types, cell framing constants and the HEC CRC-8 step used by the
// ATM UNI->NNI header translator.
package atm_pkg;

    localparam int HDR_BYTES  = 5;
    localparam int CELL_BYTES = 53;
    localparam int NVPI_W     = 12;
    localparam int FWD_W      = 4;

    localparam logic [7:0] HEC_COSET = 8'h55;

    typedef struct packed {
        logic [3:0]  gfc;
        logic [7:0]  vpi;
        logic [15:0] vci;
        logic [2:0]  pt;
        logic        clp;
    } uni_hdr_t;

    typedef struct packed {
        logic [11:0] nvpi;
        logic [15:0] vci;
        logic [2:0]  pt;
        logic        clp;
    } nni_hdr_t;

    typedef struct packed {
        logic [FWD_W-1:0]  fwd;
        logic [NVPI_W-1:0] nvpi;
    } lut_entry_t;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_HDR,
        ST_LOOKUP,
        ST_LOOKUP_RSP,
        ST_EMIT_HDR,
        ST_PAY,
        ST_DROP
    } state_t;

    // CRC-8 (x^8+x^2+x+1), MSB-first, one byte per call.
    function automatic logic [7:0] hec_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/atm_hec_gen.sv
// Byte-serial CRC-8 accumulator; clear together with step seeds the CRC with
// the first byte of a new header.
module atm_hec_gen
    import atm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (step) begin
            crc <= hec_next(clear ? 8'h00 : crc, data);
        end else if (clear) begin
            crc <= 8'h00;
        end
    end

endmodule

// File: rtl/atm_hdr_xlate.sv
// UNI->NNI cell header translator: HEC check, VPI lookup, header rewrite with
// regenerated HEC, payload pass-through, drop counting.
//
// state         | meaning
// ST_HUNT       | wait for a byte flagged in_soc
// ST_HDR        | collect UNI header bytes 1..4
// ST_LOOKUP     | LUT read strobe with the UNI VPI
// ST_LOOKUP_RSP | LUT data valid; check HEC/fwd, start emitting or drop
// ST_EMIT_HDR   | emit NNI header bytes (b4 = regenerated HEC)
// ST_PAY        | pass payload bytes 5..52 through the output register
// ST_DROP       | swallow payload bytes 5..52
module atm_hdr_xlate
    import atm_pkg::*;
#(
    parameter int NumTx = 4,
    parameter int LutAw = 8,
    parameter int CntW  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_soc,
    input  logic [7:0]          in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_soc,
    output logic                out_eoc,
    output logic [7:0]          out_data,
    output logic [NumTx-1:0]    out_fwd,
    output logic                lut_rd_en,
    output logic [LutAw-1:0]    lut_addr,
    input  logic [NumTx+11:0]   lut_rdata,
    output logic [CntW-1:0]     hec_err_cnt,
    output logic [CntW-1:0]     nofwd_cnt
);

    localparam logic [5:0] HDR_LAST  = 6'(HDR_BYTES - 1);
    localparam logic [5:0] CELL_LAST = 6'(CELL_BYTES - 1);

    state_t             state, state_nxt;
    logic [5:0]         byte_cnt, cnt_nxt;
    logic [27:0]        hdr_q;          // {vpi, vci, pt, clp}; GFC is not carried to NNI
    logic               hec_ok;
    logic [NumTx-1:0]   fwd_q;
    logic [11:0]        nvpi_q;

    logic [7:0]         crc;
    logic               hec_clr, hec_step;
    logic [7:0]         hec_din;

    logic               hdr_we;
    logic [1:0]         hdr_idx;
    logic               hec_chk;
    logic               lut_load;
    logic               out_load;
    logic [7:0]         ld_data;
    logic               ld_soc, ld_eoc;
    logic [NumTx-1:0]   ld_fwd;
    logic               hec_inc, nofwd_inc;

    logic               out_free;
    logic [NumTx-1:0]   lut_fwd;
    logic [11:0]        lut_nvpi;
    nni_hdr_t           nni;
    logic [31:0]        nni_bits;
    logic [7:0]         nni_byte;

    assign lut_fwd  = lut_rdata[NumTx+11:12];
    assign lut_nvpi = lut_rdata[11:0];
    assign out_free = !out_valid || out_ready;

    atm_hec_gen u_hec (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (hec_clr),
        .step  (hec_step),
        .data  (hec_din),
        .crc   (crc)
    );

    // NNI b0 is emitted straight from the LUT response to meet the 3-cycle latency.
    always_comb begin
        nni.nvpi = (state == ST_LOOKUP_RSP) ? lut_nvpi : nvpi_q;
        nni.vci  = hdr_q[19:4];
        nni.pt   = hdr_q[3:1];
        nni.clp  = hdr_q[0];
        nni_bits = nni;
        case (byte_cnt[1:0])
            2'd0:    nni_byte = nni_bits[31:24];
            2'd1:    nni_byte = nni_bits[23:16];
            2'd2:    nni_byte = nni_bits[15:8];
            default: nni_byte = nni_bits[7:0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        in_ready  = 1'b0;
        lut_rd_en = 1'b0;
        lut_addr  = '0;
        hec_clr   = 1'b0;
        hec_step  = 1'b0;
        hec_din   = in_data;
        hdr_we    = 1'b0;
        hdr_idx   = byte_cnt[1:0];
        hec_chk   = 1'b0;
        lut_load  = 1'b0;
        out_load  = 1'b0;
        ld_data   = in_data;
        ld_soc    = 1'b0;
        ld_eoc    = 1'b0;
        ld_fwd    = fwd_q;
        hec_inc   = 1'b0;
        nofwd_inc = 1'b0;

        case (state)
            ST_HUNT: begin
                in_ready = 1'b1;
                if (in_valid && in_soc) begin
                    hdr_we    = 1'b1;
                    hdr_idx   = 2'd0;
                    hec_clr   = 1'b1;
                    hec_step  = 1'b1;
                    cnt_nxt   = 6'd1;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_soc) begin
                        hdr_we   = 1'b1;
                        hdr_idx  = 2'd0;
                        hec_clr  = 1'b1;
                        hec_step = 1'b1;
                        cnt_nxt  = 6'd1;
                    end else if (byte_cnt == HDR_LAST) begin
                        hec_chk   = 1'b1;
                        cnt_nxt   = 6'd0;
                        state_nxt = ST_LOOKUP;
                    end else begin
                        hdr_we   = 1'b1;
                        hec_step = 1'b1;
                        cnt_nxt  = byte_cnt + 6'd1;
                    end
                end
            end
            ST_LOOKUP: begin
                lut_rd_en = 1'b1;
                lut_addr  = LutAw'(hdr_q[27:20]);
                state_nxt = ST_LOOKUP_RSP;
            end
            ST_LOOKUP_RSP: begin
                lut_load = 1'b1;
                if (!hec_ok) begin
                    hec_inc   = 1'b1;
                    cnt_nxt   = HDR_LAST + 6'd1;
                    state_nxt = ST_DROP;
                end else if (lut_fwd == '0) begin
                    nofwd_inc = 1'b1;
                    cnt_nxt   = HDR_LAST + 6'd1;
                    state_nxt = ST_DROP;
                end else begin
                    state_nxt = ST_EMIT_HDR;
                    if (out_free) begin
                        out_load = 1'b1;
                        ld_data  = nni_byte;
                        ld_soc   = 1'b1;
                        ld_fwd   = lut_fwd;
                        hec_clr  = 1'b1;
                        hec_step = 1'b1;
                        hec_din  = nni_byte;
                        cnt_nxt  = 6'd1;
                    end
                end
            end
            ST_EMIT_HDR: begin
                if (out_free) begin
                    out_load = 1'b1;
                    ld_soc   = (byte_cnt == 6'd0);
                    if (byte_cnt == HDR_LAST) begin
                        ld_data   = crc ^ HEC_COSET;
                        cnt_nxt   = HDR_LAST + 6'd1;
                        state_nxt = ST_PAY;
                    end else begin
                        ld_data  = nni_byte;
                        hec_clr  = (byte_cnt == 6'd0);
                        hec_step = 1'b1;
                        hec_din  = nni_byte;
                        cnt_nxt  = byte_cnt + 6'd1;
                    end
                end
            end
            ST_PAY: begin
                in_ready = out_free;
                if (in_valid && out_free) begin
                    out_load = 1'b1;
                    ld_eoc   = (byte_cnt == CELL_LAST);
                    if (byte_cnt == CELL_LAST) begin
                        cnt_nxt   = 6'd0;
                        state_nxt = ST_HUNT;
                    end else begin
                        cnt_nxt = byte_cnt + 6'd1;
                    end
                end
            end
            ST_DROP: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (byte_cnt == CELL_LAST) begin
                        cnt_nxt   = 6'd0;
                        state_nxt = ST_HUNT;
                    end else begin
                        cnt_nxt = byte_cnt + 6'd1;
                    end
                end
            end
            default: begin
                cnt_nxt   = 6'd0;
                state_nxt = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HUNT;
            byte_cnt    <= 6'd0;
            hdr_q       <= '0;
            hec_ok      <= 1'b0;
            fwd_q       <= '0;
            nvpi_q      <= '0;
            out_valid   <= 1'b0;
            out_soc     <= 1'b0;
            out_eoc     <= 1'b0;
            out_data    <= 8'h00;
            out_fwd     <= '0;
            hec_err_cnt <= '0;
            nofwd_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= cnt_nxt;

            if (hdr_we) begin
                case (hdr_idx)
                    2'd0:    hdr_q[27:24] <= in_data[3:0];
                    2'd1:    hdr_q[23:16] <= in_data;
                    2'd2:    hdr_q[15:8]  <= in_data;
                    default: hdr_q[7:0]   <= in_data;
                endcase
            end

            if (hec_chk) begin
                hec_ok <= (in_data == (crc ^ HEC_COSET));
            end

            if (lut_load) begin
                fwd_q  <= lut_fwd;
                nvpi_q <= lut_nvpi;
            end

            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= ld_data;
                out_soc   <= ld_soc;
                out_eoc   <= ld_eoc;
                out_fwd   <= ld_fwd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_soc   <= 1'b0;
                out_eoc   <= 1'b0;
            end

            if (hec_inc && (hec_err_cnt != {CntW{1'b1}})) begin
                hec_err_cnt <= hec_err_cnt + 1'b1;
            end
            if (nofwd_inc && (nofwd_cnt != {CntW{1'b1}})) begin
                nofwd_cnt <= nofwd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_atm_hdr_xlate.sv
// Directed bench for atm_hdr_xlate: translation, drops, backpressure and
// mid-cell reset, checked against a bit-serial HEC model.
module tb_atm_hdr_xlate;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_soc = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid, out_soc, out_eoc;
    logic [7:0]  out_data;
    logic [3:0]  out_fwd;
    logic        lut_rd_en;
    logic [7:0]  lut_addr;
    logic [15:0] lut_rdata = 16'h0000;
    logic [15:0] hec_err_cnt, nofwd_cnt;

    atm_hdr_xlate #(.NumTx(4), .LutAw(8), .CntW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_soc      (in_soc),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_soc     (out_soc),
        .out_eoc     (out_eoc),
        .out_data    (out_data),
        .out_fwd     (out_fwd),
        .lut_rd_en   (lut_rd_en),
        .lut_addr    (lut_addr),
        .lut_rdata   (lut_rdata),
        .hec_err_cnt (hec_err_cnt),
        .nofwd_cnt   (nofwd_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hec_cyc = 0;
    int rd_cyc = 0;
    logic [7:0] rd_addr = 8'h00;
    bit rand_ready = 1'b0;
    bit hold_pend = 1'b0;
    logic [14:0] hold_val = '0;

    logic [15:0] lut_mem [256];

    typedef struct {
        logic [7:0] d;
        logic       soc;
        logic       eoc;
        logic [3:0] fwd;
        int         cyc;
    } obyte_t;
    obyte_t capq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hec_model(input logic [31:0] w);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ w[i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c ^ 8'h55;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lut_rd_en) lut_rdata <= lut_mem[lut_addr];
    end

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready)
                capq.push_back('{d: out_data, soc: out_soc, eoc: out_eoc, fwd: out_fwd, cyc: cyc});
            if (lut_rd_en) begin
                rd_cyc  = cyc;
                rd_addr = lut_addr;
            end
            if (hold_pend)
                chk("stall_hold", {17'b0, out_valid, out_soc, out_eoc, out_fwd, out_data}, {17'b0, hold_val});
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_valid, out_soc, out_eoc, out_fwd, out_data};
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic send_byte(input logic soc, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_soc   = soc;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_soc   = 1'b0;
    endtask

    task automatic send_cell(input logic [31:0] hdr, input logic [7:0] hec,
                             input logic [7:0] base, input int nbytes);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            if (i < 4)       b = hdr[31-8*i -: 8];
            else if (i == 4) b = hec;
            else             b = base + 8'(i - 5);
            send_byte(i == 0, b);
            if (i == 4) hec_cyc = acc_cyc;
        end
    endtask

    task automatic check_cell(input string tag, input logic [31:0] nni, input logic [3:0] fwd,
                              input logic [7:0] base, input logic [7:0] vpi, input bit lat);
        int n;
        logic [7:0] e;
        n = 0;
        while (capq.size() < 53 && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_len"}, capq.size(), 32'd53);
        chk({tag, "_rd_lat"}, rd_cyc - hec_cyc, 32'd1);
        chk({tag, "_rd_addr"}, {24'b0, rd_addr}, {24'b0, vpi});
        if (lat && capq.size() > 0) chk({tag, "_out_lat"}, capq[0].cyc - hec_cyc, 32'd3);
        for (int i = 0; i < 53 && i < capq.size(); i++) begin
            if (i < 4)       e = nni[31-8*i -: 8];
            else if (i == 4) e = hec_model(nni);
            else             e = base + 8'(i - 5);
            chk($sformatf("%s_b%0d", tag, i),
                {18'b0, capq[i].fwd, capq[i].soc, capq[i].eoc, capq[i].d},
                {18'b0, fwd, i == 0, i == 52, e});
        end
        capq.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_outs"}, {14'b0, out_valid, out_soc, out_eoc, out_fwd, out_data, lut_rd_en, lut_addr},
            32'd0);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_hec_cnt"}, {16'b0, hec_err_cnt}, 32'd0);
        chk({tag, "_nofwd_cnt"}, {16'b0, nofwd_cnt}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] h0, h5, h7;
        h0 = 32'h0000_0000;
        h5 = {4'h0, 8'h05, 16'h1234, 3'b000, 1'b0};
        h7 = {4'h0, 8'h07, 16'h1234, 3'b000, 1'b0};
        for (int i = 0; i < 256; i++) lut_mem[i] = 16'h0000;
        lut_mem[8'h00] = {4'b0001, 12'h000};
        lut_mem[8'h05] = {4'b0010, 12'hABC};
        lut_mem[8'h07] = {4'b0000, 12'h123};

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_outputs("post_rst");

        send_cell(h0, hec_model(h0), 8'h00, 53);
        check_cell("zero", 32'h0000_0000, 4'b0001, 8'h00, 8'h00, 1'b1);

        send_cell(h5, hec_model(h5), 8'h80, 53);
        check_cell("vpi5", 32'hABC1_2340, 4'b0010, 8'h80, 8'h05, 1'b1);

        send_cell(h5, hec_model(h5) ^ 8'h01, 8'h30, 53);
        repeat (20) @(negedge clk);
        chk("bad_hec_noout", capq.size(), 32'd0);
        chk("bad_hec_cnt", {16'b0, hec_err_cnt}, 32'd1);
        chk("bad_hec_nofwd", {16'b0, nofwd_cnt}, 32'd0);
        capq.delete();
        @(posedge clk);
        #1;
        send_cell(h5, hec_model(h5), 8'h90, 53);
        check_cell("after_bad", 32'hABC1_2340, 4'b0010, 8'h90, 8'h05, 1'b1);

        send_cell(h7, hec_model(h7), 8'h40, 53);
        repeat (20) @(negedge clk);
        chk("nofwd_noout", capq.size(), 32'd0);
        chk("nofwd_cnt", {16'b0, nofwd_cnt}, 32'd1);
        chk("nofwd_hec_cnt", {16'b0, hec_err_cnt}, 32'd1);
        capq.delete();
        @(posedge clk);
        #1;

        rand_ready = 1'b1;
        send_cell(h5, hec_model(h5), 8'h80, 53);
        check_cell("stall", 32'hABC1_2340, 4'b0010, 8'h80, 8'h05, 1'b0);
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        send_cell(h5, hec_model(h5), 8'h60, 21);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_rst");
        repeat (2) @(posedge clk);
        capq.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h51);
        send_byte(1'b0, 8'h23);
        send_cell(h5, hec_model(h5), 8'h10, 53);
        check_cell("fresh", 32'hABC1_2340, 4'b0010, 8'h10, 8'h05, 1'b1);
        chk("fresh_hec_cnt", {16'b0, hec_err_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
